imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address mapped to word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: wait states per fetch when the wait feature is compiled in (range 0..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pc  input  32  fetch byte address from the core.
REQ-007 SHALL have port fetch_req  input  1  fetch request; pc is sampled when accepted.
REQ-008 SHALL have port instr  output  32  fetched instruction word.
REQ-009 SHALL have port instr_valid  output  1  one-cycle pulse: instr and fetch_fault are valid.
REQ-010 SHALL have port fetch_fault  output  1  accepted pc was misaligned or out of range.
REQ-011 SHALL have port busy  output  1  high when a new fetch_req cannot be accepted.
REQ-012 SHALL have port ld_en  input  1  program-load write strobe.
REQ-013 SHALL have port ld_addr  input  log2(DEPTH)  program-load word index.
REQ-014 SHALL have port ld_data  input  32  program-load word.

Function
REQ-015 SHALL hold a DEPTH x 32 array; ld_en writes ld_data to word ld_addr on the clock edge, in any FSM state.
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL accept fetch_req in IDLE or RESP (busy = state is WAIT), latching pc and computing word index = (pc - BASE_ADDR) >> 2.
REQ-018 SHALL flag fault when pc[1:0] != 0, pc < BASE_ADDR, or pc - BASE_ADDR >= DEPTH*4.
REQ-019 SHALL, on acceptance, go to RESP when the effective wait count is 0; otherwise go to WAIT and load a down-counter with the wait count.
REQ-020 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-021 SHALL register instr on the edge entering RESP: mem[index] if not fault, 32'h0000_0013 (NOP) if fault.
REQ-022 SHALL assert instr_valid for exactly the RESP cycle and drive fetch_fault for that cycle; fetch_fault SHALL be 0 whenever instr_valid is 0.
REQ-023 SHALL hold instr stable from one response until the next response.
REQ-024 SHALL leave RESP after one cycle: back to IDLE without fetch_req, or accept a new fetch (back-to-back) with fetch_req.
REQ-025 SHALL, on an ld_en write to the word being read on the same edge that enters RESP, return the pre-write data.
REQ-026 SHALL ignore fetch_req while busy; the requester holds fetch_req and pc until busy is low.
REQ-027 SHALL use 32-bit unsigned subtraction for the offset; the out-of-range check is made before truncation to the index width.

Reset
REQ-028 SHALL, on reset assertion, immediately force state IDLE, counter 0, instr 32'h0000_0013, instr_valid 0, fetch_fault 0, busy 0.
REQ-029 SHALL abandon an in-flight fetch on mid-operation reset with no instr_valid pulse; memory contents SHALL NOT be reset.

Configuration
REQ-030 SHALL, with macro IMEM_WAIT_STATES_EN defined, use WAIT_CYCLES as the effective wait count (latency 1 + WAIT_CYCLES cycles from acceptance edge to instr_valid).
REQ-031 SHALL, without IMEM_WAIT_STATES_EN, omit the WAIT state and counter (effective wait count 0, busy tied 0, instr_valid the cycle after acceptance).

Verification
REQ-032 SHALL cover: load 0x00500093 at word 0, fetch pc=0 (macro off) -> instr=0x00500093, instr_valid high exactly one cycle after acceptance, fault 0.
REQ-033 SHALL cover: macro on, WAIT_CYCLES=2, fetch pc=4 -> busy high 2 cycles, instr_valid on 3rd cycle after acceptance with mem[1].
REQ-034 SHALL cover: fetch pc=0x2 and pc=DEPTH*4 -> instr_valid with fetch_fault=1, instr=0x00000013.
REQ-035 SHALL cover: fetch_req held continuously with pc 0,4,8 (macro off) -> valid every cycle with words 0,1,2 in order.
REQ-036 SHALL cover: reset asserted during WAIT -> no instr_valid, instr=0x00000013; a fetch after release completes normally.
REQ-037 SHALL cover: ld_en writing word 3 on the RESP-entry edge of a pc=12 fetch -> old word returned; a refetch of pc=12 returns the new word.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction memory responder: program-loadable word array with a fetch FSM.
// Optional wait states are compiled in with IMEM_WAIT_STATES_EN.
module imem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic                     fetch_req,
    output logic [31:0]              instr,
    output logic                     instr_valid,
    output logic                     fetch_fault,
    output logic                     busy,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
    localparam logic [31:0] NOP  = 32'h0000_0013;

`ifdef IMEM_WAIT_STATES_EN
    localparam int unsigned EFF_WAIT = WAIT_CYCLES;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`else
    typedef enum logic {IDLE, RESP} state_t;
`endif

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          flt;
    logic          accept;

    // Range check uses the full 32-bit offset, before index truncation.
    always_comb begin
        off = pc - BASE_ADDR;
        idx = AW'(off >> 2);
        flt = (pc[1:0] != 2'b00) ||
              (pc < BASE_ADDR) ||
              ({1'b0, off} >= SPAN);
    end

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

`ifdef IMEM_WAIT_STATES_EN
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          flt_q;

    assign busy   = (state == WAIT);
    assign accept = fetch_req && (state != WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            idx_q       <= '0;
            flt_q       <= 1'b0;
            instr       <= NOP;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        if (EFF_WAIT == 0) begin
                            state       <= RESP;
                            instr       <= flt ? NOP : mem[idx];
                            instr_valid <= 1'b1;
                            fetch_fault <= flt;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(EFF_WAIT);
                            idx_q <= idx;
                            flt_q <= flt;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state       <= RESP;
                        instr       <= flt_q ? NOP : mem[idx_q];
                        instr_valid <= 1'b1;
                        fetch_fault <= flt_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign busy   = 1'b0;
    assign accept = fetch_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            instr       <= NOP;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            if (accept) begin
                state       <= RESP;
                instr       <= flt ? NOP : mem[idx];
                instr_valid <= 1'b1;
                fetch_fault <= flt;
            end else begin
                state <= IDLE;
            end
        end
    end
`endif

endmodule
